// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Control FSM for a shared multicycle RISC-V datapath (one memory
//            for instructions and data, one ALU that also forms PC+4 and
//            branch targets). Decodes lw, sw, R-type, I-type ALU, beq and
//            jal, stretches memory accesses with a ready handshake and traps
//            on any other opcode.
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous, active-low reset
//            op         - opcode, IR[6:0]
//            zero       - ALU zero flag
//            mem_ready  - memory completes the current access this cycle
//            memRead    - memory read request
//            memWrite   - memory write request
//            adrSrc     - memory address select (0 PC, 1 ALUOut)
//            irWrite    - load IR and OldPC
//            pcWrite    - load PC from result
//            regWrite   - register file write enable
//            resultSrc  - result mux (00 ALUOut, 01 Data, 10 ALU result)
//            aluSrcA    - ALU A mux (00 PC, 01 OldPC, 10 A)
//            aluSrcB    - ALU B mux (00 WriteData, 01 ImmExt, 10 const 4)
//            aluOp      - ALU decoder op (00 add, 01 sub, 10 funct)
//            immSrc     - immediate format (00 I, 01 S, 10 B, 11 J)
//            state_o    - current state, debug visibility
//            illegal    - sticky trap flag
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memRead,
  output logic       memWrite,
  output logic       adrSrc,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       regWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] immSrc,
  output logic [3:0] state_o,
  output logic       illegal
);

  // Opcodes handled by this controller
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd15
  } state_t;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  // Raw (ungated) Moore controls
  logic       mem_read_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       pc_update_s;
  logic       branch_s;
  logic       reg_write_s;
  logic       adr_src_s;
  logic [1:0] result_src_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;   // only reset leaves the trap
      default:    state_d = S_FETCH;  // unused encodings recover to FETCH
    endcase
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  // --------------------------------------------------------------------------
  // State and sticky trap flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // --------------------------------------------------------------------------
  // Moore control decode. Anything not set in a state stays 00 / 0.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    pc_update_s  = 1'b0;
    branch_s     = 1'b0;
    reg_write_s  = 1'b0;
    adr_src_s    = 1'b0;
    result_src_s = 2'b00;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    case (state_q)
      S_FETCH: begin
        // PC+4 is written back in the same cycle the instruction arrives
        mem_read_s   = 1'b1;
        ir_write_s   = mem_ready;
        pc_update_s  = mem_ready;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
      end
      S_DECODE: begin
        // OldPC + ImmExt lands in ALUOut as the branch/jump target
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
      end
      S_MEMREAD: begin
        adr_src_s  = 1'b1;
        mem_read_s = 1'b1;
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b10;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
      end
      S_BEQ: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b01;
        branch_s    = 1'b1;
      end
      S_JAL: begin
        // ALU forms OldPC+4 for the link while PC takes the target in ALUOut
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_update_s = 1'b1;
      end
      default: ;  // TRAP and unused codes: everything idle
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs. Strobes are gated by reset so an access in flight is abandoned
  // immediately; mux selects fall back to FETCH values via state_q.
  // --------------------------------------------------------------------------
  assign memRead   = mem_read_s  & reset;
  assign memWrite  = mem_write_s & reset;
  assign irWrite   = ir_write_s  & reset;
  assign regWrite  = reg_write_s & reset;
  assign pcWrite   = (pc_update_s | (branch_s & zero)) & reset;
  assign adrSrc    = adr_src_s;
  assign resultSrc = result_src_s;
  assign aluSrcA   = alu_src_a_s;
  assign aluSrcB   = alu_src_b_s;
  assign aluOp     = alu_op_s;
  assign state_o   = state_q;
  assign illegal   = illegal_q;

  // Immediate format follows the opcode directly
  always_comb begin
    case (op)
      OP_SW:   immSrc = 2'b01;
      OP_BEQ:  immSrc = 2'b10;
      OP_JAL:  immSrc = 2'b11;
      default: immSrc = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Directed self-checking bench for multicycle_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       memRead, memWrite, adrSrc, irWrite, pcWrite, regWrite;
  logic [1:0] resultSrc, aluSrcA, aluSrcB, aluOp, immSrc;
  logic [3:0] state_o;
  logic       illegal;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .adrSrc    (adrSrc),
    .irWrite   (irWrite),
    .pcWrite   (pcWrite),
    .regWrite  (regWrite),
    .resultSrc (resultSrc),
    .aluSrcA   (aluSrcA),
    .aluSrcB   (aluSrcB),
    .aluOp     (aluOp),
    .immSrc    (immSrc),
    .state_o   (state_o),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then examined half a cycle after the edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Strobe bundle {memRead, memWrite, irWrite, pcWrite, regWrite}
  function automatic logic [31:0] strobes();
    return {27'd0, memRead, memWrite, irWrite, pcWrite, regWrite};
  endfunction

  initial begin
    reset     = 1'b0;
    mem_ready = 1'b1;
    zero      = 1'b0;
    op        = 7'b0000000;

    // ---------------- reset ----------------
    step(); step();
    check("rst_state",   32'(state_o),   32'd0);
    check("rst_strobes", strobes(),      32'd0);
    check("rst_illegal", 32'(illegal),   32'd0);
    check("rst_srcB",    32'(aluSrcB),   32'd2);
    check("rst_result",  32'(resultSrc), 32'd2);

    reset = 1'b1;
    #1;
    // memRead, irWrite, pcWrite active in the first fetch
    check("rel_strobes", strobes(), 32'b10110);
    op = 7'b0000011;  // lw

    // ---------------- lw: 0,1,2,3,4,0 ----------------
    step(); check("lw_s1", 32'(state_o), 32'd1);
    check("lw_dec_srcA", 32'(aluSrcA), 32'd1);
    check("lw_dec_srcB", 32'(aluSrcB), 32'd1);
    check("lw_dec_regw", 32'(regWrite), 32'd0);
    step(); check("lw_s2", 32'(state_o), 32'd2);
    check("lw_adr_srcA", 32'(aluSrcA), 32'd2);
    step(); check("lw_s3", 32'(state_o), 32'd3);
    check("lw_rd_strobes", strobes(), 32'b10000);
    check("lw_rd_adrsrc", 32'(adrSrc), 32'd1);
    step(); check("lw_s4", 32'(state_o), 32'd4);
    check("lw_wb_regw", 32'(regWrite), 32'd1);
    check("lw_wb_result", 32'(resultSrc), 32'd1);
    step(); check("lw_s0", 32'(state_o), 32'd0);

    // ---------------- fetch stall ----------------
    op        = 7'b0100011;  // sw
    mem_ready = 1'b0;
    #1;
    check("fstall_strobes", strobes(), 32'b10000);
    step(); check("fstall_state", 32'(state_o), 32'd0);
    mem_ready = 1'b1;

    // ---------------- sw with 2-cycle write stall ----------------
    // instruction starts now in FETCH (cycle 1)
    step(); check("sw_s1", 32'(state_o), 32'd1);
    check("sw_imm", 32'(immSrc), 32'd1);
    step(); check("sw_s2", 32'(state_o), 32'd2);
    step(); check("sw_w1_state", 32'(state_o), 32'd5);
    mem_ready = 1'b0;
    #1;
    check("sw_w1_strobes", strobes(), 32'b01000);
    check("sw_w1_adr", 32'(adrSrc), 32'd1);
    step(); check("sw_w2_state", 32'(state_o), 32'd5);
    check("sw_w2_memw", 32'(memWrite), 32'd1);
    step(); check("sw_w3_state", 32'(state_o), 32'd5);
    mem_ready = 1'b1;
    #1;
    check("sw_w3_strobes", strobes(), 32'b01000);
    check("sw_w3_adr", 32'(adrSrc), 32'd1);
    step(); check("sw_done", 32'(state_o), 32'd0);

    // ---------------- beq taken / not taken ----------------
    for (int k = 0; k < 2; k++) begin
      op   = 7'b1100011;
      zero = (k == 0);
      step(); check("beq_s1", 32'(state_o), 32'd1);
      step(); check("beq_s9", 32'(state_o), 32'd9);
      check("beq_aluop", 32'(aluOp), 32'd1);
      check("beq_imm", 32'(immSrc), 32'd2);
      check("beq_pcw", 32'(pcWrite), (k == 0) ? 32'd1 : 32'd0);
      check("beq_regw", 32'(regWrite), 32'd0);
      step(); check("beq_s0", 32'(state_o), 32'd0);
    end
    zero = 1'b0;

    // ---------------- jal: 0,1,10,8,0 ----------------
    op = 7'b1101111;
    step(); check("jal_s1", 32'(state_o), 32'd1);
    step(); check("jal_s10", 32'(state_o), 32'd10);
    check("jal_strobes", strobes(), 32'b00010);
    check("jal_srcA", 32'(aluSrcA), 32'd1);
    check("jal_srcB", 32'(aluSrcB), 32'd2);
    check("jal_imm", 32'(immSrc), 32'd3);
    step(); check("jal_s8", 32'(state_o), 32'd8);
    check("jal_wb_strobes", strobes(), 32'b00001);
    check("jal_wb_result", 32'(resultSrc), 32'd0);
    step(); check("jal_s0", 32'(state_o), 32'd0);

    // ---------------- R-type and I-type ----------------
    op = 7'b0110011;
    step(); step(); check("r_s6", 32'(state_o), 32'd6);
    check("r_aluop", 32'(aluOp), 32'd2);
    check("r_srcB", 32'(aluSrcB), 32'd0);
    step(); check("r_s8", 32'(state_o), 32'd8);
    step(); check("r_s0", 32'(state_o), 32'd0);
    op = 7'b0010011;
    step(); step(); check("i_s7", 32'(state_o), 32'd7);
    check("i_srcB", 32'(aluSrcB), 32'd1);
    check("i_imm", 32'(immSrc), 32'd0);
    step(); check("i_s8", 32'(state_o), 32'd8);
    step(); check("i_s0", 32'(state_o), 32'd0);

    // ---------------- illegal opcode trap ----------------
    op = 7'b0001111;
    step(); check("trap_s1", 32'(state_o), 32'd1);
    check("trap_pre_ill", 32'(illegal), 32'd0);
    step();
    for (int k = 0; k < 12; k++) begin
      check("trap_state", 32'(state_o), 32'd15);
      check("trap_strobes", strobes(), 32'd0);
      check("trap_illegal", 32'(illegal), 32'd1);
      step();
    end
    reset = 1'b0;
    #1;
    check("trap_rst_state", 32'(state_o), 32'd0);
    check("trap_rst_ill", 32'(illegal), 32'd0);
    check("trap_rst_strobes", strobes(), 32'd0);
    step();
    reset = 1'b1;
    op    = 7'b0110011;
    step(); check("post_trap_s1", 32'(state_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a stuck simulation
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM that sequences the shared multicycle RISC-V datapath: a single memory for instructions and data, a single ALU that also computes PC+4 and branch targets, and non-architectural registers (IR, OldPC, A, WriteData, ALUOut, Data).
- Decodes lw, sw, R-type, I-type ALU, beq and jal.
- Stretches each memory access through a ready handshake.
- Traps on any other opcode.

Parameters:
none

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  7  opcode from IR[6:0]. Stable from the cycle after a completed fetch.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- memRead  out  1  read request to the shared memory.
- memWrite  out  1  write request to the shared memory.
- adrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- irWrite  out  1  load IR and OldPC.
- pcWrite  out  1  load PC from result.
- regWrite  out  1  register file write enable.
- resultSrc  out  2  result mux select: 00 ALUOut, 01 Data, 10 ALU result.
- aluSrcA  out  2  ALU A select: 00 PC, 01 OldPC, 10 A.
- aluSrcB  out  2  ALU B select: 00 WriteData, 01 ImmExt, 10 constant 4.
- aluOp  out  2  to the ALU decoder: 00 add, 01 sub, 10 funct-decoded.
- immSrc  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- state_o  out  4  current state, for debug and verification.
- illegal  out  1  sticky trap flag.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=15. Unused codes go to FETCH.
- Reset:
  - While reset=0: state=FETCH, illegal=0.
  - All strobes (memRead, memWrite, irWrite, pcWrite, regWrite) are forced to 0.
  - Mux selects take their FETCH values.
  - Reset mid-access abandons the access with no write.
- Outputs: Moore-decoded from the state, except:
  - pcWrite = pcUpdate | (branch & zero).
  - immSrc is decoded combinationally from op: lw/I → 00, sw → 01, beq → 10, jal → 11, other → 00.
- Unlisted selects are 00 and unlisted strobes are 0 in every state.
- FETCH:
  - adrSrc=0, memRead=1, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10.
  - irWrite=pcUpdate=mem_ready.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - aluSrcA=01, aluSrcB=01, aluOp=00; the branch target is latched into ALUOut.
  - Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BEQ
    - 1101111 → JAL
    - anything else → TRAP
- MEMADR:
  - aluSrcA=10, aluSrcB=01, aluOp=00.
  - Go to MEMREAD if op=lw, otherwise MEMWRITE.
- MEMREAD:
  - adrSrc=1, memRead=1.
  - Wait for mem_ready, then go to MEMWB.
- MEMWB:
  - resultSrc=01, regWrite=1.
  - Go to FETCH.
- MEMWRITE:
  - adrSrc=1, memWrite=1, held every cycle until mem_ready=1.
  - Go to FETCH on the mem_ready cycle.
- EXECR:
  - aluSrcA=10, aluSrcB=00, aluOp=10.
  - Go to ALUWB.
- EXECI:
  - aluSrcA=10, aluSrcB=01, aluOp=10.
  - Go to ALUWB.
- ALUWB:
  - resultSrc=00, regWrite=1.
  - Go to FETCH.
- BEQ:
  - aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, branch=1.
  - Go to FETCH. pcWrite=1 only when zero=1.
- JAL:
  - aluSrcA=01, aluSrcB=10, aluOp=00 (computes OldPC+4).
  - resultSrc=00, pcUpdate=1 (PC ← target held in ALUOut).
  - Go to ALUWB (rd ← OldPC+4).
- TRAP:
  - illegal=1, all strobes 0.
  - State is terminal until reset.
- Latency with mem_ready held at 1:
  - lw: 5 cycles
  - sw, R-type, I-type, jal: 4 cycles
  - beq: 3 cycles
- Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Exactly one of memRead/memWrite may be asserted at a time; never both.
- regWrite and memWrite are never asserted in the same cycle.
- mem_ready asserted outside FETCH, MEMREAD and MEMWRITE is ignored.

Test Plan:
- Reset with mem_ready=1, then release reset → while reset=0: state_o=0 and all strobes 0. First cycle after release: memRead=1, irWrite=1, pcWrite=1. Next cycle: state_o=1.
- op=0000011 with mem_ready=1 → state sequence 0,1,2,3,4,0. regWrite=1 only in state 4, where resultSrc=01.
- op=0100011 with mem_ready low for 2 cycles in MEMWRITE → memWrite=1 for 3 consecutive cycles with adrSrc=1, then state 0. Total instruction time 6 cycles.
- op=1100011 with zero=1, then repeated with zero=0 → BEQ cycle has aluOp=01 and immSrc=10. pcWrite=1 in the first case and 0 in the second; regWrite=0 throughout.
- op=1101111 → state sequence 0,1,10,8,0. JAL cycle has pcWrite=1, aluSrcA=01, aluSrcB=10. ALUWB cycle has regWrite=1.
- op=0001111 → DECODE then state 15, illegal=1, strobes 0 for more than 10 cycles. Asserting reset=0 mid-trap clears illegal and gives state 0.
